microsequencer_stack: RTL and testbench
=======================================

Name: microsequencer_stack

Overview:
- Parametrised microprogram sequencer for the microprogrammed control unit.
- Generalises the fixed 7-bit next-state logic in three ways:
  - configurable address width and condition count;
  - a subroutine return-address stack (call/return);
  - a bounded MOC wait with timeout fault.
- Sits between the microstore (addressed combinationally by `state`) and the control register that supplies the next-mode, invert, condition-select and CR fields.

Parameters:
- AW, 7: microstore address width; `state`, `cr` and `enc_state` are AW bits.
- NCOND, 2: number of external condition inputs.
- DEPTH, 4: return-stack entries (power of 2, ≥2).
- TIMEOUT, 16: max cycles held in WAIT mode before fault (≥2).
- RESET_ADDR, 1: state after reset.
- FETCH_ADDR, 1: target of mode FETCH and of return on empty stack.
- FAULT_ADDR, 127: target on wait timeout.

Ports:
- Clk, in, 1: clock, rising edge.
- Clr, in, 1: synchronous active-low reset.
- hold, in, 1: freeze all state when 1.
- n, in, 3: next-mode field from control register.
- inv, in, 1: condition invert.
- s, in, SW=$clog2(NCOND+1): condition select.
- cr, in, AW: microword branch/call target.
- enc_state, in, AW: decoded entry address from IR encoder.
- moc, in, 1: memory operation complete.
- cond, in, NCOND: condition flags.
- state, out, AW: current microaddress (registered).
- stack_depth, out, $clog2(DEPTH+1): entries held.
- stack_err, out, 1: sticky over/underflow flag.
- timeout, out, 1: one-cycle fault pulse.
- waiting, out, 1: combinational; 1 while mode WAIT and Sts=0.

Behaviour:

Reset and hold:
- Clr sampled low at posedge → state=RESET_ADDR, stack empty, stack_depth=0, wait counter=0, stack_err=0, timeout=0.
- Clr overrides hold; a reset mid-wait or mid-subroutine discards everything.
- hold=1 (Clr high) → no register changes; timeout forced 0.

Status and increment (combinational):
- sel = (s==0) ? moc : (s≤NCOND ? cond[s-1] : 0).
- Sts = sel ^ inv.
- inc = state+1, wrapping modulo 2^AW (127+1 → 0 at AW=7).

Next state (registered on posedge) by n:
- 0 INC: inc.
- 1 JUMP: cr.
- 2 DECODE: enc_state.
- 3 FETCH: FETCH_ADDR.
- 4 BRANCH: Sts ? cr : inc.
- 5 WAIT: Sts ? inc : state (hold address).
  - Wait counter increments each cycle Sts=0; clears on any cycle not (WAIT and Sts=0).
  - When counter reaches TIMEOUT-1 and Sts still 0 → next state=FAULT_ADDR, timeout=1 for that cycle, counter clears.
  - Sts=1 on the same edge as the limit wins: take inc, no timeout.
- 6 CALL: next=cr; push inc.
  - If stack full: push dropped, stack_err set, jump still taken.
- 7 RETURN: next=top; pop.
  - If stack empty: next=FETCH_ADDR, stack_err set.

General:
- At most one push or pop per cycle.
- stack_depth updates on the same edge as the push/pop.
- stack_err clears only on reset.
- Latency: new state visible one cycle after the microword fields are presented.

Decomposition:
- Shared package ctrl_pkg:
  - next-mode constants NM_INC, NM_JUMP, NM_DECODE, NM_FETCH, NM_BRANCH, NM_WAIT, NM_CALL, NM_RETURN (3-bit);
  - condition-select index constant SEL_MOC=0.
- One sub-module: ret_stack, a LIFO with parameters DEPTH and AW.
  - Inputs: Clk, Clr, push, pop, din.
  - Outputs: dout, depth, full, empty.
  - Overflow and underflow are ignored internally; the sequencer flags them.

Test Plan:
- Reset/INC wrap: Clr=0 one edge → state=1. Set AW=7, n=INC from state 126 → 127, then 0.
- DECODE/BRANCH: enc_state=6, n=2 → state=6. Then n=4, s=1, cond[0]=1, inv=0, cr=40 → 40. Repeat with inv=1 → 41.
- CALL/RETURN nesting:
  - CALL cr=20 at state 10 → 20, depth 1.
  - CALL cr=30 at state 21 → 30, depth 2.
  - RETURN → 22, then RETURN → 11, depth 0, stack_err=0.
- Over/underflow (DEPTH=4):
  - Five CALLs → fifth jumps, depth stays 4, stack_err=1.
  - After reset, RETURN with empty stack → state=FETCH_ADDR(1), stack_err=1.
- WAIT/MOC: n=5, s=0, moc=0 for 3 cycles then 1 at state 2.
  - state stays 2 and waiting=1 for 3 cycles, then state 3.
  - moc never rises → after 16 cycles state=127, timeout pulses once.
- hold and reset mid-op:
  - hold=1 during WAIT → counter frozen; timeout delayed by the hold cycles.
  - Clr=0 with hold=1 at depth 2 → state=1, depth 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared encodings for the microprogrammed control unit.
//   - NM_* : 3-bit next-mode field carried in the control register.
//   - SEL_MOC : condition-select index that routes the MOC line to the
//     status mux; indices 1..NCOND select cond[index-1].
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam logic [2:0] NM_INC    = 3'd0;
  localparam logic [2:0] NM_JUMP   = 3'd1;
  localparam logic [2:0] NM_DECODE = 3'd2;
  localparam logic [2:0] NM_FETCH  = 3'd3;
  localparam logic [2:0] NM_BRANCH = 3'd4;
  localparam logic [2:0] NM_WAIT   = 3'd5;
  localparam logic [2:0] NM_CALL   = 3'd6;
  localparam logic [2:0] NM_RETURN = 3'd7;

  localparam int SEL_MOC = 0;

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
//   Small LIFO holding microprogram return addresses.
//   Ports:
//     Clk   - clock, rising edge
//     Clr   - synchronous active-low reset; empties the stack
//     push  - write din on top (ignored when full)
//     pop   - discard top entry (ignored when empty)
//     din   - address to push
//     dout  - current top entry (meaningless while empty)
//     depth - number of valid entries, 0..DEPTH
//     full  - depth == DEPTH
//     empty - depth == 0
//   The owner decides what an over/underflow means; this block only refuses
//   the operation. Push has priority if both strobes are ever raised.
// ---------------------------------------------------------------------------
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 7
) (
  input  logic                           Clk,
  input  logic                           Clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [AW-1:0]                  din,
  output logic [AW-1:0]                  dout,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [DW-1:0] cnt;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  // DEPTH is a power of two, so the low bits of the count address the next
  // free slot and the slot below it is the top of stack.
  assign wr_idx  = cnt[PW-1:0];
  assign top_idx = wr_idx - PW'(1);

  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign dout  = mem[top_idx];

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Storage carries data only; the count alone defines which entries are live.
  always_ff @(posedge Clk) begin
    if (Clr && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/microsequencer_stack.sv
// ---------------------------------------------------------------------------
// microsequencer_stack
//   Next-address logic for the microprogrammed control unit. The microstore
//   is addressed combinationally by `state`; the control register feeds back
//   the next-mode (n), invert (inv), condition-select (s) and target (cr)
//   fields for the word currently addressed.
//   Ports:
//     Clk         - clock, rising edge
//     Clr         - synchronous active-low reset (overrides hold)
//     hold        - freeze every register; timeout pulse suppressed
//     n           - next-mode field (NM_* in ctrl_pkg)
//     inv         - invert selected condition
//     s           - condition select: 0 = moc, 1..NCOND = cond[s-1], else 0
//     cr          - branch / call target
//     enc_state   - entry address from the instruction decoder
//     moc         - memory operation complete
//     cond        - external condition flags
//     state       - current microaddress
//     stack_depth - return-stack occupancy
//     stack_err   - sticky overflow/underflow flag
//     timeout     - one-cycle pulse when a WAIT exceeds its budget
//     waiting     - combinational: mode WAIT with status low
// ---------------------------------------------------------------------------
module microsequencer_stack
  import ctrl_pkg::*;
#(
  parameter int unsigned AW         = 7,
  parameter int unsigned NCOND      = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned RESET_ADDR = 1,
  parameter int unsigned FETCH_ADDR = 1,
  parameter int unsigned FAULT_ADDR = 127
) (
  input  logic                             Clk,
  input  logic                             Clr,
  input  logic                             hold,
  input  logic [2:0]                       n,
  input  logic                             inv,
  input  logic [$clog2(NCOND+1)-1:0]       s,
  input  logic [AW-1:0]                    cr,
  input  logic [AW-1:0]                    enc_state,
  input  logic                             moc,
  input  logic [NCOND-1:0]                 cond,
  output logic [AW-1:0]                    state,
  output logic [$clog2(DEPTH+1)-1:0]       stack_depth,
  output logic                             stack_err,
  output logic                             timeout,
  output logic                             waiting
);

  localparam int CW = $clog2(TIMEOUT);

  logic          sel;
  logic          sts;
  logic [AW-1:0] inc;
  logic [AW-1:0] next_state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nxt;
  logic          fault;
  logic          err_set;
  logic          push_req;
  logic          pop_req;
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_top;
  logic          stk_full;
  logic          stk_empty;
  logic          timeout_r;

  // Status selection: out-of-range selects read as a constant 0 so an
  // unused encoding can never branch on stale wiring.
  always_comb begin
    sel = 1'b0;
    if (int'(s) == SEL_MOC) begin
      sel = moc;
    end else begin
      for (int i = 0; i < int'(NCOND); i++) begin
        if (int'(s) == i + 1) begin
          sel = cond[i];
        end
      end
    end
  end

  assign sts     = sel ^ inv;
  assign inc     = state + AW'(1);
  assign waiting = (n == NM_WAIT) && !sts;
  assign timeout = timeout_r;

  // Next-address selection. The wait counter only survives cycles that are
  // WAIT with status low; any other cycle returns it to zero.
  always_comb begin
    next_state   = state;
    wait_cnt_nxt = '0;
    fault        = 1'b0;
    err_set      = 1'b0;
    push_req     = 1'b0;
    pop_req      = 1'b0;
    case (n)
      NM_INC:    next_state = inc;
      NM_JUMP:   next_state = cr;
      NM_DECODE: next_state = enc_state;
      NM_FETCH:  next_state = AW'(FETCH_ADDR);
      NM_BRANCH: next_state = sts ? cr : inc;
      NM_WAIT: begin
        // Status arriving on the limit edge wins over the fault.
        if (sts) begin
          next_state = inc;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          next_state = AW'(FAULT_ADDR);
          fault      = 1'b1;
        end else begin
          next_state   = state;
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      NM_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        next_state = cr;
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end
      NM_RETURN: begin
        if (stk_empty) begin
          next_state = AW'(FETCH_ADDR);
          err_set    = 1'b1;
        end else begin
          next_state = stk_top;
          pop_req    = 1'b1;
        end
      end
      default: next_state = inc;
    endcase
  end

  // Stack operations are gated by hold so the LIFO freezes with the rest of
  // the sequencer.
  assign stk_push = push_req && !hold;
  assign stk_pop  = pop_req && !hold;

  ret_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ret_stack (
    .Clk   (Clk),
    .Clr   (Clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (inc),
    .dout  (stk_top),
    .depth (stack_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Sequencer registers
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state     <= AW'(RESET_ADDR);
      wait_cnt  <= '0;
      stack_err <= 1'b0;
      timeout_r <= 1'b0;
    end else if (hold) begin
      timeout_r <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_nxt;
      stack_err <= stack_err | err_set;
      timeout_r <= fault;
    end
  end

endmodule

// File: tb/tb_microsequencer_stack.sv
module tb_microsequencer_stack;
  import ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       hold = 1'b0;
  logic [2:0] n = NM_INC;
  logic       inv = 1'b0;
  logic [1:0] s = 2'd0;
  logic [6:0] cr = 7'd0;
  logic [6:0] enc_state = 7'd0;
  logic       moc = 1'b0;
  logic [1:0] cond = 2'd0;
  logic [6:0] state;
  logic [2:0] stack_depth;
  logic       stack_err;
  logic       timeout;
  logic       waiting;

  microsequencer_stack dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .hold        (hold),
    .n           (n),
    .inv         (inv),
    .s           (s),
    .cr          (cr),
    .enc_state   (enc_state),
    .moc         (moc),
    .cond        (cond),
    .state       (state),
    .stack_depth (stack_depth),
    .stack_err   (stack_err),
    .timeout     (timeout),
    .waiting     (waiting)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      nm;
    logic [2:0] n;
    logic [6:0] cr;
    logic [6:0] st;
    logic [2:0] dp;
    logic       er;
    logic       to;
    logic       wt;
    logic       inv;
    logic [1:0] s;
    logic [1:0] cond;
    logic       moc;
    logic [6:0] enc;
    logic       hold;
    logic       clr;
  } step_t;

  typedef struct {
    string      nm;
    logic [6:0] st;
    logic [2:0] dp;
    logic       er;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic step_t mk(input string nm, input logic [2:0] nn, input logic [6:0] c,
                               input logic [6:0] st, input logic [2:0] dp, input logic er,
                               input logic to, input logic wt, input logic iv = 1'b0,
                               input logic [1:0] sl = 2'd0, input logic [1:0] cd = 2'd0,
                               input logic mc = 1'b0, input logic [6:0] en = 7'd0,
                               input logic hd = 1'b0, input logic cl = 1'b1);
    step_t t;
    t.nm = nm; t.n = nn; t.cr = c; t.st = st; t.dp = dp; t.er = er; t.to = to; t.wt = wt;
    t.inv = iv; t.s = sl; t.cond = cd; t.moc = mc; t.enc = en; t.hold = hd; t.clr = cl;
    return t;
  endfunction

  task automatic apply(input step_t t);
    n = t.n; cr = t.cr; inv = t.inv; s = t.s; cond = t.cond;
    moc = t.moc; enc_state = t.enc; hold = t.hold; Clr = t.clr;
  endtask

  task automatic test_reset();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("reset", NM_INC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("inc_after_reset", NM_INC, 0, 2, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_inc_wrap();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("jump126", NM_JUMP, 126, 126, 0, 0, 0, 0));
    q.push_back(mk("inc127", NM_INC, 0, 127, 0, 0, 0, 0));
    q.push_back(mk("inc_wrap", NM_INC, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("fetch", NM_FETCH, 55, 1, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_decode_branch();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("decode", NM_DECODE, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    q.push_back(mk("br_c0_taken", NM_BRANCH, 40, 40, 0, 0, 0, 0, 0, 1, 2'b01));
    q.push_back(mk("br_c0_inv", NM_BRANCH, 40, 41, 0, 0, 0, 0, 1, 1, 2'b01));
    q.push_back(mk("br_c1_taken", NM_BRANCH, 50, 50, 0, 0, 0, 0, 0, 2, 2'b10));
    q.push_back(mk("br_c1_low", NM_BRANCH, 20, 51, 0, 0, 0, 0, 0, 2, 2'b01));
    q.push_back(mk("br_sel_oob", NM_BRANCH, 60, 52, 0, 0, 0, 0, 0, 3, 2'b11));
    q.push_back(mk("br_sel_oob_inv", NM_BRANCH, 60, 60, 0, 0, 0, 0, 1, 3, 2'b00));
    q.push_back(mk("br_moc", NM_BRANCH, 70, 70, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_call_return();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("jump10", NM_JUMP, 10, 10, 0, 0, 0, 0));
    q.push_back(mk("call20", NM_CALL, 20, 20, 1, 0, 0, 0));
    q.push_back(mk("inc21", NM_INC, 0, 21, 1, 0, 0, 0));
    q.push_back(mk("call30", NM_CALL, 30, 30, 2, 0, 0, 0));
    q.push_back(mk("ret22", NM_RETURN, 0, 22, 1, 0, 0, 0));
    q.push_back(mk("ret11", NM_RETURN, 0, 11, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("call50", NM_CALL, 50, 50, 1, 0, 0, 0));
    q.push_back(mk("call60", NM_CALL, 60, 60, 2, 0, 0, 0));
    q.push_back(mk("call70", NM_CALL, 70, 70, 3, 0, 0, 0));
    q.push_back(mk("call80", NM_CALL, 80, 80, 4, 0, 0, 0));
    q.push_back(mk("call90_ovf", NM_CALL, 90, 90, 4, 1, 0, 0));
    q.push_back(mk("ret_after_ovf", NM_RETURN, 0, 71, 3, 1, 0, 0));
    q.push_back(mk("rst", NM_INC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("jump33", NM_JUMP, 33, 33, 0, 0, 0, 0));
    q.push_back(mk("ret_empty", NM_RETURN, 0, 1, 0, 1, 0, 0));
    q.push_back(mk("err_sticky", NM_INC, 0, 2, 0, 1, 0, 0));
    q.push_back(mk("rst_clear", NM_INC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_wait_moc();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("inc2", NM_INC, 0, 2, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) q.push_back(mk("wait_hold", NM_WAIT, 0, 2, 0, 0, 0, 1));
    q.push_back(mk("wait_moc", NM_WAIT, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk("jump2_a", NM_JUMP, 2, 2, 0, 0, 0, 0));
    for (int k = 0; k < 15; k++) q.push_back(mk("wait_count", NM_WAIT, 0, 2, 0, 0, 0, 1));
    q.push_back(mk("wait_timeout", NM_WAIT, 0, 127, 0, 0, 1, 1));
    q.push_back(mk("after_timeout", NM_INC, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("jump2_b", NM_JUMP, 2, 2, 0, 0, 0, 0));
    for (int k = 0; k < 15; k++) q.push_back(mk("wait_count2", NM_WAIT, 0, 2, 0, 0, 0, 1));
    q.push_back(mk("moc_at_limit", NM_WAIT, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk("wait_cond_inv", NM_WAIT, 0, 4, 0, 0, 0, 0, 1, 1, 2'b00));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_hold();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("jump2", NM_JUMP, 2, 2, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) q.push_back(mk("wait_pre", NM_WAIT, 0, 2, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      q.push_back(mk("wait_held", NM_WAIT, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) q.push_back(mk("wait_post", NM_WAIT, 0, 2, 0, 0, 0, 1));
    q.push_back(mk("wait_late_timeout", NM_WAIT, 0, 127, 0, 0, 1, 1));
    q.push_back(mk("hold_kills_pulse", NM_INC, 0, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk("hold_call", NM_CALL, 99, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk("release", NM_INC, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("jump10", NM_JUMP, 10, 10, 0, 0, 0, 0));
    q.push_back(mk("call20", NM_CALL, 20, 20, 1, 0, 0, 0));
    q.push_back(mk("call30", NM_CALL, 30, 30, 2, 0, 0, 0));
    q.push_back(mk("wait_once", NM_WAIT, 0, 30, 2, 0, 0, 1));
    q.push_back(mk("rst_with_hold", NM_WAIT, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    q.push_back(mk("ret_after_rst", NM_RETURN, 0, 1, 0, 1, 0, 0));
    q.push_back(mk("rst_final", NM_INC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("b2b_call40", NM_CALL, 40, 40, 1, 0, 0, 0));
    q.push_back(mk("b2b_ret2", NM_RETURN, 0, 2, 0, 0, 0, 0));
    q.push_back(mk("b2b_call50", NM_CALL, 50, 50, 1, 0, 0, 0));
    q.push_back(mk("b2b_ret3", NM_RETURN, 0, 3, 0, 0, 0, 0));
    q.push_back(mk("b2b_fetch", NM_FETCH, 0, 1, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back('{q[i].nm, q[i].st, q[i].dp, q[i].er, q[i].to});
      #1;
      checks++;
      if (waiting !== q[i].wt) begin
        failures++;
        $display("FAIL %s waiting got=%b want=%b", q[i].nm, waiting, q[i].wt);
      end
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({state, stack_depth, stack_err, timeout} !== {e.st, e.dp, e.er, e.to}) begin
        failures++;
        $display("FAIL %s got st=%0d dp=%0d err=%b to=%b want st=%0d dp=%0d err=%b to=%b",
                 e.nm, state, stack_depth, stack_err, timeout, e.st, e.dp, e.er, e.to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_decode_branch();
    test_call_return();
    test_overflow_underflow();
    test_wait_moc();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
